// File: rtl/des_pkg.sv
// Shared DES constants, permutation tables, S-boxes and helper functions for the
// iterative DES core and its round slice.
package des_pkg;

  localparam int unsigned DES_BLOCK_W  = 64;
  localparam int unsigned DES_HALF_W   = 32;
  localparam int unsigned DES_SUBKEY_W = 48;
  localparam int unsigned DES_CD_W     = 28;

  typedef enum logic [1:0] {StIdle, StRun, StDone} des_state_e;

  // Entries are 1-based DES bit numbers; DES bit 1 is the MSB of the bus.
  localparam byte unsigned IP_TBL [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam byte unsigned FP_TBL [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25
  };

  localparam byte unsigned E_TBL [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
  };

  localparam byte unsigned P_TBL [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };

  localparam byte unsigned PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam byte unsigned PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  localparam byte unsigned SHIFT_TBL [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Indexed by {row, column} = {b1, b6, b2..b5}.
  localparam logic [3:0] SBOX [8][64] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
      0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
      4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
      15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
    '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
      3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
      0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
      13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
    '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
      13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
      1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
    '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
      13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
      10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
      3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
    '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
      14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
      4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
      11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
    '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
      10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
      9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
      4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
    '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
      13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
      1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
      6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
    '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
      1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
      7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
      2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}
  };

  function automatic logic [63:0] des_ip(input logic [63:0] x);
    logic [63:0] y;
    for (int k = 0; k < 64; k++) y[63-k] = x[64-int'(IP_TBL[k])];
    return y;
  endfunction

  function automatic logic [63:0] des_fp(input logic [63:0] x);
    logic [63:0] y;
    for (int k = 0; k < 64; k++) y[63-k] = x[64-int'(FP_TBL[k])];
    return y;
  endfunction

  function automatic logic [55:0] des_pc1(input logic [63:0] x);
    logic [55:0] y;
    for (int k = 0; k < 56; k++) y[55-k] = x[64-int'(PC1_TBL[k])];
    return y;
  endfunction

  function automatic logic [47:0] des_pc2(input logic [55:0] x);
    logic [47:0] y;
    for (int k = 0; k < 48; k++) y[47-k] = x[56-int'(PC2_TBL[k])];
    return y;
  endfunction

  function automatic logic [47:0] des_e(input logic [31:0] x);
    logic [47:0] y;
    for (int k = 0; k < 48; k++) y[47-k] = x[32-int'(E_TBL[k])];
    return y;
  endfunction

  function automatic logic [31:0] des_p(input logic [31:0] x);
    logic [31:0] y;
    for (int k = 0; k < 32; k++) y[31-k] = x[32-int'(P_TBL[k])];
    return y;
  endfunction

  function automatic logic [31:0] des_sbox(input logic [47:0] x);
    logic [31:0] y;
    logic [5:0]  b;
    for (int n = 0; n < 8; n++) begin
      b = x[47-6*n -: 6];
      y[31-4*n -: 4] = SBOX[n][{b[5], b[0], b[4:1]}];
    end
    return y;
  endfunction

  function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
    return des_p(des_sbox(des_e(r) ^ k));
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[26:0], x[27]};
      2'd2:    return {x[25:0], x[27:26]};
      default: return x;
    endcase
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[0], x[27:1]};
      2'd2:    return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

endpackage

// File: rtl/des_round.sv
// One combinational DES round: key-schedule rotation, PC2 subkey and Feistel step.
// Encrypt rotates left before each round; decrypt rotates right after the first.
module des_round
  import des_pkg::*;
(
  input  logic [DES_HALF_W-1:0] l_i,
  input  logic [DES_HALF_W-1:0] r_i,
  input  logic [DES_CD_W-1:0]   c_i,
  input  logic [DES_CD_W-1:0]   d_i,
  input  logic                  mode_i,
  input  logic [3:0]            round_i,
  output logic [DES_HALF_W-1:0] l_o,
  output logic [DES_HALF_W-1:0] r_o,
  output logic [DES_CD_W-1:0]   c_o,
  output logic [DES_CD_W-1:0]   d_o
);

  logic [1:0]              shamt;
  logic [3:0]              dec_idx;
  logic [DES_SUBKEY_W-1:0] subkey;

  // Decrypt round i uses SHIFT[18-i]; as a 0-based index that is (16 - round_i) mod 16.
  assign dec_idx = 4'd0 - round_i;

  always_comb begin
    shamt = 2'(SHIFT_TBL[round_i]);
    if (mode_i) begin
      shamt = (round_i == 4'd0) ? 2'd0 : 2'(SHIFT_TBL[dec_idx]);
    end
  end

  assign c_o    = mode_i ? rotr28(c_i, shamt) : rotl28(c_i, shamt);
  assign d_o    = mode_i ? rotr28(d_i, shamt) : rotl28(d_i, shamt);
  assign subkey = des_pc2({c_o, d_o});
  assign l_o    = r_i;
  assign r_o    = l_i ^ des_f(r_i, subkey);

endmodule

// File: rtl/des_iter_core.sv
// Iterative DES encrypt/decrypt core with valid/ready handshakes; evaluates
// ROUNDS_PER_CYCLE unrolled rounds per clock for 16/ROUNDS_PER_CYCLE RUN cycles.
module des_iter_core
  import des_pkg::*;
#(
  parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  input  logic                   MODE,
  input  logic [DES_BLOCK_W-1:0] KEY,
  input  logic [DES_BLOCK_W-1:0] DATA_IN,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [DES_BLOCK_W-1:0] DATA_OUT,
  output logic                   BUSY
);

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
        ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16)) begin : g_bad_rpc
    $error("des_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  localparam int unsigned NUM_ITER = 16 / ROUNDS_PER_CYCLE;
  localparam int unsigned CntW     = $clog2(NUM_ITER + 1);

  des_state_e             state_q, state_d;
  logic [DES_HALF_W-1:0]  l_q, l_d, r_q, r_d;
  logic [DES_CD_W-1:0]    c_q, c_d, d_q, d_d;
  logic                   mode_q, mode_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [DES_BLOCK_W-1:0] dout_q, dout_d;
  logic                   last_iter;

  logic [DES_HALF_W-1:0] l_c [ROUNDS_PER_CYCLE+1];
  logic [DES_HALF_W-1:0] r_c [ROUNDS_PER_CYCLE+1];
  logic [DES_CD_W-1:0]   c_c [ROUNDS_PER_CYCLE+1];
  logic [DES_CD_W-1:0]   d_c [ROUNDS_PER_CYCLE+1];

  assign l_c[0] = l_q;
  assign r_c[0] = r_q;
  assign c_c[0] = c_q;
  assign d_c[0] = d_q;

  for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_round
    logic [3:0] round_idx;
    assign round_idx = 4'(ROUNDS_PER_CYCLE * 32'(cnt_q) + j);

    des_round u_round (
      .l_i    (l_c[j]),
      .r_i    (r_c[j]),
      .c_i    (c_c[j]),
      .d_i    (d_c[j]),
      .mode_i (mode_q),
      .round_i(round_idx),
      .l_o    (l_c[j+1]),
      .r_o    (r_c[j+1]),
      .c_o    (c_c[j+1]),
      .d_o    (d_c[j+1])
    );
  end

  assign last_iter = (cnt_q == CntW'(NUM_ITER - 1));

  always_comb begin
    state_d = state_q;
    l_d     = l_q;
    r_d     = r_q;
    c_d     = c_q;
    d_d     = d_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    case (state_q)
      StIdle: begin
        if (IN_VALID) begin
          {l_d, r_d} = des_ip(DATA_IN);
          {c_d, d_d} = des_pc1(KEY);
          mode_d     = MODE;
          cnt_d      = '0;
          state_d    = StRun;
        end
      end
      StRun: begin
        l_d   = l_c[ROUNDS_PER_CYCLE];
        r_d   = r_c[ROUNDS_PER_CYCLE];
        c_d   = c_c[ROUNDS_PER_CYCLE];
        d_d   = d_c[ROUNDS_PER_CYCLE];
        cnt_d = cnt_q + 1'b1;
        if (last_iter) begin
          // Final swap: output is FP(R16 || L16).
          dout_d  = des_fp({r_c[ROUNDS_PER_CYCLE], l_c[ROUNDS_PER_CYCLE]});
          state_d = StDone;
        end
      end
      StDone: begin
        if (OUT_READY) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      l_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      r_q     <= r_d;
      c_q     <= c_d;
      d_q     <= d_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

  assign IN_READY  = (state_q == StIdle);
  assign OUT_VALID = (state_q == StDone);
  assign BUSY      = (state_q != StIdle);
  assign DATA_OUT  = dout_q;

endmodule
